// File: rtl/modn_seq.sv
// modn_seq: restoring shift-subtract reduction x = a mod b, one bit per clock.
// Build option MODN_QUOTIENT_EN adds the quotient output q.
module modn_seq #(
  parameter int DATA_WIDTH        = 8,
  parameter int DATA_DOUBLE_WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         rst,
  input  logic                         en,
  input  logic [DATA_DOUBLE_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0]        b,
  output logic [DATA_WIDTH-1:0]        x,
  output logic                         ready
`ifdef MODN_QUOTIENT_EN
  ,
  output logic [DATA_DOUBLE_WIDTH-1:0] q
`endif
);

  localparam int W  = DATA_WIDTH;
  localparam int DW = DATA_DOUBLE_WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST = CW'(DW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [DW-1:0]  a_sh;
  logic [W-1:0]   b_r;
  logic [W-1:0]   rem;
  logic [CW-1:0]  cnt;
  logic [W:0]     t;
  logic           ge;
  logic [W-1:0]   rem_nx;

  // rem < b_r always holds, so W bits store it; t needs W+1 for the compare
  always_comb begin
    t      = {rem, a_sh[DW-1]};
    ge     = (t >= {1'b0, b_r});
    rem_nx = ge ? (t[W-1:0] - b_r) : t[W-1:0];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (en) begin
          state_nx = (b == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (cnt == LAST) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
    if (rst) begin
      state_nx = S_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_sh  <= '0;
      b_r   <= '0;
      rem   <= '0;
      cnt   <= '0;
      x     <= '0;
      ready <= 1'b0;
    end else if (rst) begin
      rem   <= '0;
      cnt   <= '0;
      x     <= '0;
      ready <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (en) begin
            a_sh <= a;
            b_r  <= b;
            rem  <= '0;
            cnt  <= '0;
          end
        end
        S_CALC: begin
          a_sh <= {a_sh[DW-2:0], 1'b0};
          rem  <= rem_nx;
          cnt  <= cnt + 1'b1;
        end
        S_DONE: begin
          x     <= (b_r == '0) ? '0 : rem;
          ready <= 1'b1;
        end
        default: begin
          ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef MODN_QUOTIENT_EN
  logic [DW-1:0] q_sh;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_sh <= '0;
      q    <= '0;
    end else if (rst) begin
      q_sh <= '0;
      q    <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (en) begin
            q_sh <= '0;
          end
        end
        S_CALC: q_sh <= {q_sh[DW-2:0], ge};
        S_DONE: q <= (b_r == '0) ? '0 : q_sh;
        default: q <= '0;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_modn_seq.sv
// tb_modn_seq: directed checks of modn_seq remainder, latency, aborts, hold.
// Define MODN_QUOTIENT_EN to also check the quotient output.
module tb_modn_seq;

  logic        clock;
  logic        reset_n;
  logic        rst;
  logic        en;
  logic [15:0] a;
  logic [7:0]  b;
  logic [7:0]  x;
  logic        ready;
`ifdef MODN_QUOTIENT_EN
  logic [15:0] q;
`endif

  int checks = 0;
  int errors = 0;

  modn_seq #(
    .DATA_WIDTH(8),
    .DATA_DOUBLE_WIDTH(16)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .rst(rst),
    .en(en),
    .a(a),
    .b(b),
    .x(x),
    .ready(ready)
`ifdef MODN_QUOTIENT_EN
    ,
    .q(q)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Re-arm with rst, then launch one operation; returns 1 ns after start edge
  task automatic start_op(input logic [15:0] av, input logic [7:0] bv);
    rst = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    chk("rearm_ready", {31'd0, ready}, 32'd0);
    a  = av;
    b  = bv;
    en = 1'b1;
    @(posedge clock);
    #1;
    en = 1'b0;
    a  = 16'($urandom);
    b  = 8'($urandom);
  endtask

  task automatic wait_done(input string tag, input int lat,
                           input logic [7:0] ex, input logic [15:0] eq);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_x"}, {24'd0, x}, {24'd0, ex});
`ifdef MODN_QUOTIENT_EN
    chk({tag, "_q"}, {16'd0, q}, {16'd0, eq});
`else
    if (eq == 16'hFFFF) begin
      $display("note: quotient 0xFFFF not checked in this build");
    end
`endif
  endtask

  initial begin
    reset_n = 1'b0;
    rst     = 1'b0;
    en      = 1'b0;
    a       = '0;
    b       = '0;
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_x", {24'd0, x}, 32'd0);
    #20;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("post_rst_ready", {31'd0, ready}, 32'd0);

    start_op(16'd300, 8'd7);
    wait_done("t1_300_7", 17, 8'd6, 16'd42);

    start_op(16'hFFFF, 8'hFF);
    wait_done("t2_ffff_ff", 17, 8'd0, 16'd257);
    start_op(16'hFFFF, 8'hFE);
    wait_done("t2_ffff_fe", 17, 8'd3, 16'd258);

    start_op(16'd5, 8'd200);
    wait_done("t3_5_200", 17, 8'd5, 16'd0);
    start_op(16'd200, 8'd1);
    wait_done("t3_200_1", 17, 8'd0, 16'd200);

    start_op(16'd1234, 8'd0);
    wait_done("t4_b0", 1, 8'd0, 16'd0);

    // Abort by rst in the middle of CALC
    start_op(16'd300, 8'd7);
    repeat (5) @(posedge clock);
    #1;
    rst = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    chk("abort_ready", {31'd0, ready}, 32'd0);
    chk("abort_x", {24'd0, x}, 32'd0);
    repeat (20) @(posedge clock);
    #1;
    chk("abort_no_result", {31'd0, ready}, 32'd0);
    start_op(16'd300, 8'd7);
    wait_done("t5_rerun", 17, 8'd6, 16'd42);

    // Async reset between edges: during CALC, then during DONE
    start_op(16'd300, 8'd7);
    repeat (3) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_calc_ready", {31'd0, ready}, 32'd0);
    chk("arst_calc_x", {24'd0, x}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(posedge clock);
    #1;
    chk("arst_no_resume", {31'd0, ready}, 32'd0);
    start_op(16'd300, 8'd7);
    wait_done("t5_arst_pre", 17, 8'd6, 16'd42);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_done_ready", {31'd0, ready}, 32'd0);
    chk("arst_done_x", {24'd0, x}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Hold in DONE with en high and changing operands
    start_op(16'hFFFF, 8'hFE);
    wait_done("t6_hold_pre", 17, 8'd3, 16'd258);
    en = 1'b1;
    a  = 16'd300;
    b  = 8'd7;
    for (int i = 0; i < 20; i++) begin
      @(posedge clock);
      #1;
      chk("hold_ready", {31'd0, ready}, 32'd1);
      chk("hold_x", {24'd0, x}, 32'd3);
    end

    // rst and en together: back to IDLE with no new start
    rst = 1'b1;
    en  = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    en  = 1'b0;
    chk("rst_en_ready", {31'd0, ready}, 32'd0);
    chk("rst_en_x", {24'd0, x}, 32'd0);
    repeat (20) @(posedge clock);
    #1;
    chk("rst_en_no_start", {31'd0, ready}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
